// File: rtl/cmd_uart_wrapper_if.sv
// rtl/cmd_uart_wrapper_if.sv - handshake bundle between UART, wrapper and command processor
// Purpose: groups the UART receive/transmit handshakes and the command/response
//          handshakes of cmd_uart_wrapper into one bundle.
// Signals:  rx_rdy, rx_data, clr_rx_rdy  - UART receiver byte handshake
//           trmt, tx_data, tx_done        - UART transmitter handshake
//           cmd, cmd_rdy, clr_cmd_rdy     - assembled 16-bit command to processor
//           send_resp                     - response request from processor
// Modports: slave  - the wrapper side
//           master - the UART / command processor side
interface cmd_uart_wrapper_if;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;

  modport slave (
    input  rx_rdy, rx_data, tx_done, clr_cmd_rdy, send_resp,
    output clr_rx_rdy, trmt, tx_data, cmd, cmd_rdy
  );

  modport master (
    output rx_rdy, rx_data, tx_done, clr_cmd_rdy, send_resp,
    input  clr_rx_rdy, trmt, tx_data, cmd, cmd_rdy
  );
endinterface

// File: rtl/cmd_uart_wrapper.sv
// rtl/cmd_uart_wrapper.sv - assembles 2-byte UART commands and sends response bytes
// Purpose: RX path collects a high byte then a low byte into a 16-bit command,
//          with an inter-byte timeout that discards a lone high byte. TX path
//          issues one RESP byte per send_resp, buffering one extra request.
// Ports:   clk   - system clock, rising edge
//          rst_n - asynchronous active-low reset
//          bus   - cmd_uart_wrapper_if.slave handshake bundle
// Params:  RESP    - response byte
//          TMO_CYC - inter-byte timeout in clk cycles (>= 2)
module cmd_uart_wrapper #(
  parameter logic [7:0] RESP    = 8'hA5,
  parameter int         TMO_CYC = 50000
) (
  input logic              clk,
  input logic              rst_n,
  cmd_uart_wrapper_if.slave bus
);

  localparam int            CW       = $clog2(TMO_CYC);
  localparam logic [CW-1:0] TMO_LAST = CW'(TMO_CYC - 1);

  typedef enum logic {WAIT_HI, WAIT_LO} rx_state_t;
  typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;

  rx_state_t   rx_state;
  tx_state_t   tx_state;
  logic [7:0]  hi;
  logic [CW-1:0] cnt;
  logic [15:0] cmd_q;
  logic        cmd_rdy_q;
  logic        pending;
  logic        tx_fire;

  // The receiver byte is consumed in whichever RX state it arrives, so the
  // clear pulse needs no state decode; rst_n gating keeps it low in reset.
  assign bus.clr_rx_rdy = rst_n & bus.rx_rdy;

  // A send_resp coincident with tx_done behaves like a pending request.
  always_comb begin
    tx_fire = 1'b0;
    if (tx_state == TX_IDLE)
      tx_fire = bus.send_resp;
    else
      tx_fire = bus.tx_done & (pending | bus.send_resp);
  end

  assign bus.trmt    = rst_n & tx_fire;
  assign bus.tx_data = RESP;
  assign bus.cmd     = cmd_q;
  assign bus.cmd_rdy = cmd_rdy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state  <= WAIT_HI;
      hi        <= 8'h00;
      cnt       <= '0;
      cmd_q     <= 16'h0000;
      cmd_rdy_q <= 1'b0;
    end else begin
      // Consumer clear first so that a low-byte capture below overrides it.
      if (bus.clr_cmd_rdy) cmd_rdy_q <= 1'b0;
      case (rx_state)
        WAIT_HI: begin
          if (bus.rx_rdy) begin
            hi        <= bus.rx_data;
            cmd_rdy_q <= 1'b0;
            cnt       <= '0;
            rx_state  <= WAIT_LO;
          end
        end
        WAIT_LO: begin
          // A byte arriving on the last timeout cycle still wins.
          if (bus.rx_rdy) begin
            cmd_q     <= {hi, bus.rx_data};
            cmd_rdy_q <= 1'b1;
            rx_state  <= WAIT_HI;
          end else if (cnt == TMO_LAST) begin
            hi       <= 8'h00;
            cnt      <= '0;
            rx_state <= WAIT_HI;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: rx_state <= WAIT_HI;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      pending  <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          pending <= 1'b0;
          if (bus.send_resp) tx_state <= TX_BUSY;
        end
        TX_BUSY: begin
          if (bus.tx_done) begin
            // Pending (or a coincident request) restarts the transmitter;
            // any request beyond the one being served is dropped.
            pending <= 1'b0;
            if (!(pending | bus.send_resp)) tx_state <= TX_IDLE;
          end else if (bus.send_resp) begin
            pending <= 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_uart_wrapper.sv
// tb/tb_cmd_uart_wrapper.sv - scoreboard testbench for cmd_uart_wrapper
module tb_cmd_uart_wrapper;
  localparam int         TMO  = 16;
  localparam logic [7:0] RESP = 8'hA5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  logic [7:0]  rx_q[$];
  logic [15:0] cmd_q[$];
  logic [7:0]  tx_q[$];
  logic        prev_cmd_rdy = 1'b0;

  cmd_uart_wrapper_if bus();

  cmd_uart_wrapper #(.RESP(RESP), .TMO_CYC(TMO)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_rdy  = 1'b1;
    bus.rx_data = b;
    rx_q.push_back(b);
    tick(1);
    bus.rx_rdy  = 1'b0;
  endtask

  // Monitor: pops the expected value whenever the DUT presents an output event.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.clr_rx_rdy) begin
        if (rx_q.size() == 0) check("unexpected_clr_rx_rdy", 1, 0);
        else check("rx_byte_consumed", {24'h0, bus.rx_data}, {24'h0, rx_q.pop_front()});
      end
      if (bus.cmd_rdy && !prev_cmd_rdy) begin
        if (cmd_q.size() == 0) check("unexpected_cmd_rdy", {16'h0, bus.cmd}, 32'hFFFF_FFFF);
        else check("cmd_value", {16'h0, bus.cmd}, {16'h0, cmd_q.pop_front()});
      end
      if (bus.trmt) begin
        if (tx_q.size() == 0) check("unexpected_trmt", 1, 0);
        else check("tx_data", {24'h0, bus.tx_data}, {24'h0, tx_q.pop_front()});
      end
    end
    prev_cmd_rdy = bus.cmd_rdy;
  end

  initial begin
    bus.rx_rdy = 1'b0; bus.rx_data = 8'h00; bus.tx_done = 1'b0;
    bus.clr_cmd_rdy = 1'b0; bus.send_resp = 1'b0;

    // Reset: pulses must stay low even with requests asserted.
    tick(2);
    bus.rx_rdy = 1'b1; bus.send_resp = 1'b1;
    #1;
    check("rst_clr_rx_rdy", {31'h0, bus.clr_rx_rdy}, 0);
    check("rst_trmt", {31'h0, bus.trmt}, 0);
    check("rst_cmd", {16'h0, bus.cmd}, 0);
    check("rst_cmd_rdy", {31'h0, bus.cmd_rdy}, 0);
    check("rst_tx_data", {24'h0, bus.tx_data}, {24'h0, RESP});
    bus.rx_rdy = 1'b0; bus.send_resp = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(2);

    // Two-byte command, bytes 5 cycles apart.
    send_byte(8'h20);
    tick(4);
    cmd_q.push_back(16'h203F);
    send_byte(8'h3F);
    check("cmd_rdy_after_lo", {31'h0, bus.cmd_rdy}, 1);
    check("cmd_203f", {16'h0, bus.cmd}, 32'h203F);

    // Consumer clear, then a new high byte must not disturb cmd.
    bus.clr_cmd_rdy = 1'b1;
    tick(1);
    bus.clr_cmd_rdy = 1'b0;
    check("cmd_rdy_cleared", {31'h0, bus.cmd_rdy}, 0);
    check("cmd_kept_after_clr", {16'h0, bus.cmd}, 32'h203F);
    send_byte(8'h40);
    tick(3);
    check("cmd_stable_during_hi", {16'h0, bus.cmd}, 32'h203F);
    cmd_q.push_back(16'h4001);
    send_byte(8'h01);

    // Timeout: lone high byte discarded after TMO idle cycles.
    send_byte(8'h60);
    check("hi_clears_cmd_rdy", {31'h0, bus.cmd_rdy}, 0);
    tick(TMO);
    check("no_cmd_rdy_after_tmo", {31'h0, bus.cmd_rdy}, 0);
    check("cmd_kept_after_tmo", {16'h0, bus.cmd}, 32'h4001);
    cmd_q.push_back(16'h1122);
    send_byte(8'h11);
    tick(2);
    send_byte(8'h22);
    check("cmd_1122", {16'h0, bus.cmd}, 32'h1122);

    // Low byte on the last timeout cycle is still accepted.
    send_byte(8'h33);
    tick(TMO - 1);
    cmd_q.push_back(16'h3344);
    send_byte(8'h44);
    check("cmd_3344_boundary", {16'h0, bus.cmd}, 32'h3344);

    // Low-byte capture coincident with clr_cmd_rdy: set wins.
    send_byte(8'h55);
    bus.clr_cmd_rdy = 1'b1;
    cmd_q.push_back(16'h5566);
    send_byte(8'h66);
    bus.clr_cmd_rdy = 1'b0;
    check("set_wins_over_clr", {31'h0, bus.cmd_rdy}, 1);

    // TX: one immediate, one pending, one dropped.
    bus.send_resp = 1'b1; tx_q.push_back(RESP);
    tick(1);
    bus.send_resp = 1'b0;
    tick(2);
    bus.send_resp = 1'b1; tick(1); bus.send_resp = 1'b0;
    tick(1);
    bus.send_resp = 1'b1; tick(1); bus.send_resp = 1'b0;
    tick(3);
    bus.tx_done = 1'b1; tx_q.push_back(RESP);
    tick(1);
    bus.tx_done = 1'b0;
    tick(3);
    bus.tx_done = 1'b1; tick(1); bus.tx_done = 1'b0;
    tick(3);
    check("tx_q_drained_1", tx_q.size(), 0);

    // send_resp coincident with tx_done and no pending restarts transmit.
    bus.send_resp = 1'b1; tx_q.push_back(RESP);
    tick(1);
    bus.send_resp = 1'b0;
    tick(2);
    bus.send_resp = 1'b1; bus.tx_done = 1'b1; tx_q.push_back(RESP);
    tick(1);
    bus.send_resp = 1'b0; bus.tx_done = 1'b0;
    tick(2);
    bus.tx_done = 1'b1; tick(1); bus.tx_done = 1'b0;
    tick(2);
    bus.send_resp = 1'b1; tx_q.push_back(RESP);
    tick(1);
    bus.send_resp = 1'b0;
    bus.tx_done = 1'b1; tick(1); bus.tx_done = 1'b0;
    tick(2);
    check("tx_q_drained_2", tx_q.size(), 0);

    // Reset mid-command and mid-transmit.
    send_byte(8'h77);
    bus.send_resp = 1'b1; tx_q.push_back(RESP);
    tick(1);
    bus.send_resp = 1'b0;
    rst_n = 1'b0;
    bus.send_resp = 1'b1; bus.rx_rdy = 1'b1;
    #1;
    check("rst2_cmd", {16'h0, bus.cmd}, 0);
    check("rst2_cmd_rdy", {31'h0, bus.cmd_rdy}, 0);
    check("rst2_trmt", {31'h0, bus.trmt}, 0);
    check("rst2_clr_rx_rdy", {31'h0, bus.clr_rx_rdy}, 0);
    bus.send_resp = 1'b0; bus.rx_rdy = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    bus.tx_done = 1'b1; tick(1); bus.tx_done = 1'b0;
    tick(1);
    cmd_q.push_back(16'h789A);
    send_byte(8'h78);
    tick(1);
    send_byte(8'h9A);
    check("cmd_789a_after_rst", {16'h0, bus.cmd}, 32'h789A);

    tick(3);
    check("rx_q_empty", rx_q.size(), 0);
    check("cmd_q_empty", cmd_q.size(), 0);
    check("tx_q_empty_final", tx_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cmd_uart_wrapper.md
CMD_UART_WRAPPER -- requirements
Module: cmd_uart_wrapper

Interface
REQ-001 SHALL provide parameter RESP, default 8'hA5, the response byte transmitted per send_resp.
REQ-002 SHALL provide parameter TMO_CYC, default 50000, the inter-byte timeout in clk cycles (>=2).
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rx_rdy  input  1  UART receiver holds a valid byte.
REQ-006 SHALL have port rx_data  input  8  received byte, valid while rx_rdy=1.
REQ-007 SHALL have port clr_rx_rdy  output  1  pulse consuming the receiver byte.
REQ-008 SHALL have port trmt  output  1  one-cycle pulse starting a UART transmit.
REQ-009 SHALL have port tx_data  output  8  byte to transmit, constant RESP.
REQ-010 SHALL have port tx_done  input  1  UART transmitter finished the current byte.
REQ-011 SHALL have port cmd  output  16  assembled command {high byte, low byte}.
REQ-012 SHALL have port cmd_rdy  output  1  cmd holds a new, unconsumed command.
REQ-013 SHALL have port clr_cmd_rdy  input  1  command processor consumed cmd.
REQ-014 SHALL have port send_resp  input  1  pulse requesting one response byte.

Function
REQ-015 SHALL implement RX FSM with states WAIT_HI and WAIT_LO; high byte is received first.
REQ-016 In WAIT_HI with rx_rdy=1: clr_rx_rdy=1 combinationally that cycle; rx_data captured into hi register; cmd_rdy cleared; timeout counter zeroed; next state WAIT_LO.
REQ-017 In WAIT_LO with rx_rdy=1: clr_rx_rdy=1 that cycle; cmd <= {hi, rx_data} and cmd_rdy <= 1 at the next edge; next state WAIT_HI.
REQ-018 clr_rx_rdy SHALL be 0 in every cycle other than those in REQ-016/017.
REQ-019 cmd SHALL change only at low-byte capture; it stays stable while cmd_rdy=1 and during reception of a following high byte.
REQ-020 In WAIT_LO the timeout counter SHALL increment each cycle without rx_rdy; on reaching TMO_CYC-1 the FSM returns to WAIT_HI, hi is discarded, cmd and cmd_rdy unchanged.
REQ-021 rx_rdy arriving in the same cycle the counter reaches TMO_CYC-1 SHALL be accepted as the low byte (byte wins over timeout).
REQ-022 cmd_rdy SHALL clear on clr_cmd_rdy=1 or on high-byte capture; a simultaneous set (REQ-017) and clr_cmd_rdy SHALL leave cmd_rdy=1.
REQ-023 SHALL implement TX FSM with states TX_IDLE and TX_BUSY plus a one-deep pending flag.
REQ-024 In TX_IDLE with send_resp=1: trmt=1 for exactly that cycle, next state TX_BUSY.
REQ-025 In TX_BUSY, send_resp=1 SHALL set pending; a further send_resp while pending=1 SHALL be dropped.
REQ-026 In TX_BUSY with tx_done=1: if pending, clear pending, assert trmt the same cycle, remain TX_BUSY; else go TX_IDLE.
REQ-027 send_resp coincident with tx_done in TX_BUSY and pending=0 SHALL behave as pending (trmt that cycle, stay TX_BUSY).
REQ-028 tx_data SHALL equal RESP at all times; RX and TX paths SHALL operate independently and concurrently.

Reset
REQ-029 On rst_n=0 (asynchronous, any time incl. mid-byte or mid-transmit): RX=WAIT_HI, TX=TX_IDLE, pending=0, counter=0, hi=8'h00, cmd=16'h0000, cmd_rdy=0; clr_rx_rdy and trmt SHALL be 0 while reset asserted.

Verification
REQ-030 Bytes 8'h20 then 8'h3F (rx_rdy one cycle each, 5 cycles apart) -> clr_rx_rdy pulse each byte; cmd=16'h203F, cmd_rdy=1 one cycle after second byte.
REQ-031 cmd_rdy=1, clr_cmd_rdy pulse -> cmd_rdy=0 next edge, cmd still 16'h203F; new high byte 8'h40 -> cmd unchanged until its low byte.
REQ-032 Byte 8'h60, then idle TMO_CYC cycles, then 8'h11, 8'h22 -> no cmd_rdy after 8'h60; final cmd=16'h1122.
REQ-033 send_resp in TX_IDLE -> trmt one cycle, tx_data=8'hA5; send_resp twice more during busy -> exactly one extra trmt on tx_done, third dropped.
REQ-034 Low byte captured in the same cycle as clr_cmd_rdy -> cmd_rdy=1 after the edge.
REQ-035 rst_n low after high byte and during TX_BUSY -> all outputs at REQ-029 values; subsequent 2-byte sequence assembles correctly.
